// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encodings, FSM state encoding and the default operand width.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_DIVU  = 3'b001,
        OP_MTHI  = 3'b010,
        OP_MTLO  = 3'b011,
        OP_MULT  = 3'b100,
        OP_DIV   = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Datapath <-> multiply/divide sequencer request/result bundle.
// master = datapath side, slave = sequencer side.
interface muldiv_sequencer_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration on {acc, shr}:
//   mul: LSB-first shift-add, multiplier in shr, multiplicand in opb.
//   div: restoring trial subtract, dividend in shr, divisor in opb;
//        quotient bits shift into shr, remainder builds up in acc.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shr,
    input  logic [WIDTH-1:0] i_opb,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shr
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_qbit;

    // Select shift-add or trial-subtract result for this iteration.
    always_comb begin
        w_sum     = {1'b0, i_acc} + (i_shr[0] ? {1'b0, i_opb} : '0);
        w_shifted = {i_acc, i_shr[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, i_opb};
        w_qbit    = ~w_diff[WIDTH];
        if (i_div) begin
            o_acc = w_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
            o_shr = {i_shr[WIDTH-2:0], w_qbit};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_shr = {w_sum[0], i_shr[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide controller with private HI/LO registers.
// Optional macro MULDIV_SIGNED_EN adds MULT/DIV via magnitude iteration
// followed by a one-cycle sign-fix state.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);
    localparam int unsigned CNTW = $clog2(WIDTH) + 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shr;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             w_mul_op;
    logic             w_div_op;
    logic             w_last;
    logic [WIDTH-1:0] w_a_op;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_shr_nxt;
`ifdef MULDIV_SIGNED_EN
    logic               r_signed;
    logic               r_is_mul;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               w_sgn_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
`endif

    assign w_last   = (r_cnt == CNTW'(WIDTH - 1));
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_state == S_DIV),
        .i_acc (r_acc),
        .i_shr (r_shr),
        .i_opb (r_opb),
        .o_acc (w_acc_nxt),
        .o_shr (w_shr_nxt)
    );

    // Decode the request and form the operands the iteration will see.
    always_comb begin
        w_mul_op = (bus.op == OP_MULTU);
        w_div_op = (bus.op == OP_DIVU);
        w_a_op   = bus.a;
        w_b_op   = bus.b;
`ifdef MULDIV_SIGNED_EN
        w_sgn_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        w_mul_op = w_mul_op || (bus.op == OP_MULT);
        w_div_op = w_div_op || (bus.op == OP_DIV);
        w_a_neg  = w_sgn_op & bus.a[WIDTH-1];
        w_b_neg  = w_sgn_op & bus.b[WIDTH-1];
        if (w_a_neg) w_a_op = -bus.a;
        if (w_b_neg) w_b_op = -bus.b;
`endif
    end

`ifdef MULDIV_SIGNED_EN
    // Sign correction of the magnitude result held in {acc, shr}.
    always_comb begin
        w_prod = {r_acc, r_shr};
        if (r_neg_lo) w_prod = -w_prod;
        if (r_is_mul) begin
            {w_fix_hi, w_fix_lo} = w_prod;
        end else begin
            w_fix_hi = r_neg_hi ? -r_acc : r_acc;
            w_fix_lo = r_neg_lo ? -r_shr : r_shr;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_mul_op)      w_state_nxt = S_MUL;
                    else if (w_div_op) w_state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
`ifdef MULDIV_SIGNED_EN
                    w_state_nxt = r_signed ? S_FIX : S_IDLE;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand/iteration registers, HI/LO and the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_shr  <= '0;
            r_opb  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_signed <= 1'b0;
            r_is_mul <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_mul_op || w_div_op) begin
                            r_cnt <= '0;
                            r_acc <= '0;
                            r_shr <= w_mul_op ? w_b_op : w_a_op;
                            r_opb <= w_mul_op ? w_a_op : w_b_op;
`ifdef MULDIV_SIGNED_EN
                            r_signed <= w_sgn_op;
                            r_is_mul <= w_mul_op;
                            r_neg_lo <= w_a_neg ^ w_b_neg;
                            r_neg_hi <= w_a_neg;
`endif
                        end else if (bus.op == OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_acc_nxt;
                    r_shr <= w_shr_nxt;
                    r_cnt <= r_cnt + CNTW'(1);
`ifdef MULDIV_SIGNED_EN
                    if (w_last && !r_signed) begin
`else
                    if (w_last) begin
`endif
                        r_hi   <= w_acc_nxt;
                        r_lo   <= w_shr_nxt;
                        r_done <= 1'b1;
                    end
                end
                S_FIX: begin
`ifdef MULDIV_SIGNED_EN
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: table of vectors plus
// hand-written multi-cycle sequences; results go through a scoreboard queue.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_hilo = '0;
    vec_t vecs[$];

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count busy cycles from the current negedge, then check done and HI/LO.
    task automatic wait_result(input int ecyc, input string name);
        int cyc = 0;
        logic [63:0] exp;
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk({name, " busy cycles"}, 64'(cyc), 64'(ecyc));
        chk({name, " done"}, 64'(bus.done), 64'd1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        chk({name, " hi:lo"}, {bus.hi, bus.lo}, exp);
        last_hilo = exp;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int ecyc, input string name);
        sb_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        wait_result(ecyc, name);
        @(negedge clk);
        chk({name, " done drop"}, 64'(bus.done), 64'd0);
    endtask

    // A request that must leave HI/LO and busy/done untouched.
    task automatic do_noop(input logic [2:0] op, input string name);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = 32'hA5A5_A5A5; bus.b = 32'h3;
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, " busy"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk({name, " done"}, 64'(bus.done), 64'd0);
        chk({name, " hi:lo"}, {bus.hi, bus.lo}, last_hilo);
    endtask

    initial begin
        logic [31:0] ra, rb;

        vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32});
        vecs.push_back('{OP_DIVU,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 32});
        vecs.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 32});
        vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF, 32});
        vecs.push_back('{OP_DIVU,  32'd5,         32'd9,         32'd5,         32'd0,         32});
        vecs.push_back('{OP_MULTU, 32'h0,         32'd12345,     32'h0,         32'h0,         32});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{OP_MULT,  -32'sd3,       32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33});
        vecs.push_back('{OP_DIV,   -32'sd7,       32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
        vecs.push_back('{OP_DIV,   32'd7,         -32'sd2,       32'd1,         32'hFFFF_FFFD, 33});
        vecs.push_back('{OP_MULT,  -32'sd4,       -32'sd6,       32'd0,         32'd24,        33});
`endif

        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst hi:lo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;

        // Table vectors
        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo},
                  vecs[i].cyc, $sformatf("vec%0d", i));

        // Random unsigned operands against a reference model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(OP_MULTU, ra, rb, 64'(ra) * 64'(rb), 32, $sformatf("rmul%0d", i));
            rb = (rb >> $urandom_range(0, 28)) | 32'd1;
            do_op(OP_DIVU, ra, rb, {ra % rb, ra / rb}, 32, $sformatf("rdiv%0d", i));
        end

        // DIVU 100/7 with a start issued mid-busy that must be ignored
        sb_q.push_back({32'd2, 32'd14});
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign hi:lo held", {bus.hi, bus.lo}, last_hilo);
        wait_result(26, "div100_7");
        @(negedge clk);
        chk("ign not queued busy", 64'(bus.busy), 64'd0);
        chk("ign hi:lo after", {bus.hi, bus.lo}, {32'd2, 32'd14});

        // New start in the same cycle as done is accepted
        sb_q.push_back({32'd0, 32'd42});
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd6; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_result(32, "b2b_mul");
        sb_q.push_back({32'd0, 32'd10});
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd50; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_result(32, "b2b_div");

        // MTHI then MTLO back-to-back: zero stall
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'd5;
        @(negedge clk);
        chk("mthi hi", 64'(bus.hi), 64'd5);
        chk("mthi busy", 64'(bus.busy), 64'd0);
        bus.op = OP_MTLO; bus.a = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo hi:lo", {bus.hi, bus.lo}, {32'd5, 32'd9});
        chk("mtlo busy", 64'(bus.busy), 64'd0);
        chk("mtlo done", 64'(bus.done), 64'd0);
        last_hilo = {32'd5, 32'd9};

        // Reserved ops are no-ops
        do_noop(3'b110, "rsv110");
        do_noop(3'b111, "rsv111");
`ifndef MULDIV_SIGNED_EN
        do_noop(3'b100, "nosign100");
        do_noop(3'b101, "nosign101");
`endif

        // Reset mid-MULTU aborts without done
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort hi:lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        chk("abort done", 64'(bus.done), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort done later", 64'(bus.done), 64'd0);
        chk("abort idle", 64'(bus.busy), 64'd0);
        do_op(OP_MULTU, 32'd3, 32'd4, {32'd0, 32'd12}, 32, "post_rst_mul");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller with its own HI/LO register pair. It sits beside the single-cycle datapath's ALU. The datapath issues a MULTU/DIVU (plus MTHI/MTLO) with a one-cycle `start` pulse, stalls the program counter while `busy` is high, and reads the results through `hi`/`lo` for MFHI/MFLO. This removes the single-cycle 32×32 multiply from the ALU critical path and adds division.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Must be a power of two ≥ 8.
- `CNTW`, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-low.
- `start`  in  1: operation request. Sampled only while `busy`=0.
- `op`  in  3: operation code, sampled with `start`:
  - 000 MULTU
  - 001 DIVU
  - 010 MTHI
  - 011 MTLO
  - 100 MULT
  - 101 DIV
  - 11x reserved
- `a`  in  WIDTH: srca (multiplicand / dividend / MTHI-MTLO source).
- `b`  in  WIDTH: srcb (multiplier / divisor).
- `busy`  out  1: iterative operation in progress. The datapath holds the PC while this is high.
- `done`  out  1: one-cycle pulse, the cycle after HI/LO take the result.
- `hi`  out  WIDTH: HI register (product upper half / remainder).
- `lo`  out  WIDTH: LO register (product lower half / quotient).

## Operation
- States:
  - IDLE
  - MUL: radix-2 shift-add, one bit per cycle.
  - DIV: restoring, one bit per cycle.
  - FIX: signed correction (see Configuration).
- Reset (async, `reset`=0): state IDLE; `busy`=0; `done`=0; `hi`=`lo`=0; counter=0; internal operand registers=0.
- IDLE with `start`=1:
  - MULTU: latch `a`/`b`, clear the accumulator, go to MUL.
  - DIVU: latch `a`/`b`, clear the partial remainder, go to DIV.
  - MTHI: `hi`<=`a`, stay IDLE. No `busy`, no `done`.
  - MTLO: `lo`<=`a`, stay IDLE. No `busy`, no `done`.
  - Reserved op: no-op.
- MUL/DIV:
  - Counter counts 0..WIDTH-1.
  - On the last iteration, write the 2·WIDTH result into {`hi`,`lo`} and return to IDLE. `done`=1 for the following cycle.
- MULTU: {hi,lo} = a·b, full 2·WIDTH-bit unsigned product. No overflow.
- DIVU: lo = a / b, hi = a % b, unsigned.
- Divide by zero: not trapped. Runs the full WIDTH iterations and yields lo = all ones, hi = a. This falls out naturally from the restoring algorithm and is required.
- `start` while `busy`=1: ignored, not queued. The datapath's stall prevents this in normal operation.
- `hi`/`lo` hold their previous values throughout MUL/DIV; intermediate state is never visible.
- `done` and a new `start` in the same cycle: the new op is accepted, since `busy`=0 in that cycle.

## Timing
- `start` sampled at edge E0 → `busy`=1 from E0 through E(WIDTH). That is exactly WIDTH cycles for unsigned ops, or WIDTH+1 cycles with FIX.
- `hi`/`lo` update at the edge that drops `busy`.
- `done` is high for exactly the one cycle following that edge.
- MTHI/MTLO: result visible one cycle after `start` (E0). Zero stall.
- `hi`/`lo` are direct register outputs with no combinational path from inputs. MFHI in the cycle after `done` reads the new value.
- Reset asserted mid-operation: immediate abort to IDLE. `hi`/`lo` are cleared, and no `done` pulse is produced.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - Ops 100 (MULT) and 101 (DIV) are supported.
  - Operands are converted to magnitude on accept, and result signs are recorded.
  - After the last iteration the block enters FIX for one cycle, which two's-complement negates:
    - the product, if operand signs differ;
    - the quotient, if signs differ;
    - the remainder, if the dividend is negative.
  - Signed ops are therefore busy for WIDTH+1 cycles. Unsigned ops skip FIX.
  - Signed divide by zero: same raw result as unsigned on the magnitudes, then FIX applied.
- `MULDIV_SIGNED_EN` undefined:
  - Ops 100/101 are reserved no-ops.
  - The FIX state and sign logic are absent.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings (`OP_MULTU` … `OP_DIV`);
  - state encoding typedef;
  - `WIDTH` default.
- One sub-module: `muldiv_step`, combinational. It implements a single shift-add / trial-subtract iteration on {hi-accumulator, lo-shift register} and is selected by a mul/div flag. The sequencer owns the FSM, counter, sign handling and HI/LO.

## Test plan
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → `busy` exactly 32 cycles; then hi=32'hFFFF_FFFE, lo=32'h0000_0001, `done` one cycle.
- DIVU a=100, b=7 → lo=14, hi=2 after 32 busy cycles. Second `start` issued mid-busy is ignored (hi/lo unchanged by it).
- DIVU a=32'h1234_5678, b=0 → lo=32'hFFFF_FFFF, hi=32'h1234_5678. No hang.
- MTHI a=5, then MTLO a=9 back-to-back → hi=5, lo=9 one cycle after each `start`; `busy` never asserted.
- Reset pulled low at iteration 10 of a MULTU → `busy`=0, hi=lo=0 immediately. No `done`. Next MULTU 3×4 → lo=12, hi=0.
- With `MULDIV_SIGNED_EN`:
  - MULT a=-3, b=5 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1, busy 33 cycles.
  - DIV a=-7, b=2 → lo=-3, hi=-1.
- Without the macro: op=100 → no state change.
